// File: rtl/test_compare.sv
// test_compare: scoreboard that compares retired-instruction records from a
// design under test against expected records queued by a reference model.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   check_en, check_pc/data/addr record retired by the design this cycle
//   exp_valid, exp_ready         push handshake for the expected-record FIFO
//   exp_pc/data/addr             expected record fields
//   end_of_test                  one-cycle pulse: stimulus finished
//   pass, fail, done             verdict flags (done is sticky)
//   match_cnt, mismatch_cnt      saturating compare counters
//   err_pc, err_field, err_kind  capture of the first error
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | nothing pushed or checked yet
// RUN    | comparing, no error so far
// FAIL   | an error was seen; compares still counted, error capture frozen
// PASS   | clean end of test; terminal, inputs ignored
module test_compare #(
   parameter int DEPTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             check_en,
   input  logic [31:0]      check_pc,
   input  logic [31:0]      check_data,
   input  logic [31:0]      check_addr,
   input  logic             exp_valid,
   output logic             exp_ready,
   input  logic [31:0]      exp_pc,
   input  logic [31:0]      exp_data,
   input  logic [31:0]      exp_addr,
   input  logic             end_of_test,
   output logic             pass,
   output logic             fail,
   output logic             done,
   output logic [CNT_W-1:0] match_cnt,
   output logic [CNT_W-1:0] mismatch_cnt,
   output logic [31:0]      err_pc,
   output logic [2:0]       err_field,
   output logic [1:0]       err_kind
);

   localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [31:0] WILDCARD = 32'hDEAD_BEEF;

   localparam logic [1:0] KIND_MISMATCH  = 2'd1;
   localparam logic [1:0] KIND_UNDERFLOW = 2'd2;
   localparam logic [1:0] KIND_LEFTOVER  = 2'd3;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FAIL, S_PASS} state_t;

   state_t        state;
   logic [31:0]   mem_pc   [DEPTH];
   logic [31:0]   mem_data [DEPTH];
   logic [31:0]   mem_addr [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [AW:0]   count_next;

   logic       full;
   logic       empty;
   logic       push;
   logic       checking;
   logic       pop;
   logic       underflow;
   logic       mismatch;
   logic [2:0] miss;

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);

   // Ready depends only on registered state, so a pop in the same cycle
   // never opens a slot for a push into a full FIFO.
   assign exp_ready = ~full & (state != S_PASS);
   assign push      = exp_valid & exp_ready;

   // Emptiness is taken before this cycle's push, so a record pushed into an
   // empty FIFO is never compared in the same cycle.
   assign checking  = check_en & (state != S_PASS);
   assign pop       = checking & ~empty;
   assign underflow = checking & empty;

   assign miss[0] = (mem_pc[rd_ptr]   != check_pc)   && (mem_pc[rd_ptr]   != WILDCARD);
   assign miss[1] = (mem_data[rd_ptr] != check_data) && (mem_data[rd_ptr] != WILDCARD);
   assign miss[2] = (mem_addr[rd_ptr] != check_addr) && (mem_addr[rd_ptr] != WILDCARD);
   assign mismatch = pop & (|miss);

   assign count_next = count + (AW+1)'(push) - (AW+1)'(pop);

   assign pass = (state == S_PASS);
   assign fail = (state == S_FAIL);

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         done         <= 1'b0;
         match_cnt    <= '0;
         mismatch_cnt <= '0;
         err_pc       <= '0;
         err_field    <= '0;
         err_kind     <= '0;
      end else begin
         if (push) begin
            mem_pc[wr_ptr]   <= exp_pc;
            mem_data[wr_ptr] <= exp_data;
            mem_addr[wr_ptr] <= exp_addr;
            wr_ptr           <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
            if (mismatch) begin
               if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + CNT_W'(1);
            end else begin
               if (match_cnt != '1) match_cnt <= match_cnt + CNT_W'(1);
            end
         end
         count <= count_next;

         if (end_of_test) done <= 1'b1;

         case (state)
            S_IDLE, S_RUN: begin
               // The compare outcome outranks end_of_test in the same cycle.
               if (underflow) begin
                  state     <= S_FAIL;
                  err_kind  <= KIND_UNDERFLOW;
                  err_pc    <= check_pc;
                  err_field <= 3'b000;
               end else if (mismatch) begin
                  state     <= S_FAIL;
                  err_kind  <= KIND_MISMATCH;
                  err_pc    <= check_pc;
                  err_field <= miss;
               end else if (end_of_test) begin
                  if (count_next == '0) begin
                     state <= S_PASS;
                  end else begin
                     state    <= S_FAIL;
                     err_kind <= KIND_LEFTOVER;
                  end
               end else if (state == S_IDLE && (push || check_en)) begin
                  state <= S_RUN;
               end
            end
            S_FAIL:  state <= S_FAIL;
            S_PASS:  state <= S_PASS;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/test_compare.md
TEST_COMPARE -- requirements
Module: test_compare

Interface
REQ-001 Parameter DEPTH, default 8, sets expected-record FIFO depth; power of two, 2..64.
REQ-002 Parameter CNT_W, default 16, sets width of match/mismatch counters.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 check_en  input  1  a retired-instruction record is presented this cycle.
REQ-006 check_pc / check_data / check_addr  input  32 each  DUT record fields (PC, memory write data, memory write address).
REQ-007 exp_valid  input  1  expected record offered by the reference model.
REQ-008 exp_ready  output  1  FIFO accepts a push this cycle.
REQ-009 exp_pc / exp_data / exp_addr  input  32 each  expected record fields.
REQ-010 end_of_test  input  1  single-cycle pulse: stimulus finished.
REQ-011 pass / fail / done  output  1 each  verdict flags.
REQ-012 match_cnt / mismatch_cnt  output  CNT_W each  compare counters.
REQ-013 err_pc  output  32  check_pc of the first error.
REQ-014 err_field  output  3  first-mismatch fields: bit0 pc, bit1 data, bit2 addr.
REQ-015 err_kind  output  2  first error: 0 none, 1 mismatch, 2 underflow, 3 leftover.

Function
REQ-016 FIFO: push when exp_valid & exp_ready; exp_ready = ~full & (state is IDLE, RUN or FAIL).
REQ-017 When full, exp_ready SHALL be 0 even if a pop occurs the same cycle; no push when full.
REQ-018 Pop when check_en=1 and FIFO non-empty; a same-cycle push into an empty FIFO SHALL NOT be bypassed to the compare.
REQ-019 Compare per field: field matches if equal or if the expected field is 32'hDEADBEEF (wildcard).
REQ-020 Record matches only if all three fields match; mismatch vector = per-field miss bits.
REQ-021 Compare latency 1: counters, flags and error capture SHALL reflect a check_en sampled at edge N immediately after edge N.
REQ-022 match_cnt / mismatch_cnt increment by 1 per compare and SHALL saturate at all-ones.
REQ-023 check_en=1 with FIFO empty = underflow: no pop, no counter change, error of kind 2, err_field=000.
REQ-024 States: IDLE, RUN, FAIL, PASS.
REQ-025 IDLE->RUN on the first accepted push or first check_en.
REQ-026 IDLE or RUN -> FAIL on first mismatch or underflow.
REQ-027 RUN -> on end_of_test: PASS if FIFO empty after this cycle's pop; otherwise FAIL, err_kind 3.
REQ-028 end_of_test in IDLE SHALL go to PASS (empty test).
REQ-029 In FAIL, compares and counting SHALL continue; err_pc/err_field/err_kind frozen at the first error.
REQ-030 PASS is terminal: check_en ignored, exp_ready=0, counters frozen.
REQ-031 Same-cycle check_en and end_of_test: compare applied first; a mismatch or underflow in that compare SHALL give FAIL with kind 1/2 rather than PASS.
REQ-032 pass = (state==PASS); fail = (state==FAIL); done SHALL be set sticky by end_of_test in any state.

Reset
REQ-033 rst SHALL have priority over all inputs, in any state, including mid-test.
REQ-034 rst SHALL empty the FIFO, set state IDLE, and clear every output to 0 except exp_ready, which is 1 in the cycle after rst deasserts.
REQ-035 Records pushed or presented during the rst cycle SHALL be discarded.

Verification
REQ-036 Push 3 records (PC 0x0,0x4,0x8), then 3 matching check_en, then end_of_test -> match_cnt=3, mismatch_cnt=0, pass=1, done=1.
REQ-037 Expected data 0x12345678 vs check_data 0x12345679 at PC 0x4 -> one cycle later fail=1, err_kind=1, err_field=010, err_pc=0x4; a later mismatch leaves err_* unchanged and gives mismatch_cnt=2.
REQ-038 check_en with empty FIFO at PC 0x10 -> fail=1, err_kind=2, err_pc=0x10, counters 0.
REQ-039 Push DEPTH records with no checks -> exp_ready=0; one check_en -> exp_ready=1 next cycle, no push lost or duplicated.
REQ-040 Two records pushed, one checked, end_of_test -> fail=1, err_kind=3, done=1. Expected addr 0xDEADBEEF vs any check_addr -> counted as a match.
REQ-041 rst asserted mid-test with 4 records queued and fail=1 -> all outputs 0, FIFO empty, then a fresh 1-record pass sequence -> pass=1.
